doc_fetch_scheduler: RTL and testbench

DOC_FETCH_SCHEDULER -- requirements
Module: doc_fetch_scheduler

---
 rtl/aug_pkg.sv | 27 ++
 rtl/doc_len_scan.sv | 33 +++
 rtl/doc_fetch_scheduler.sv | 276 +++++++++++++++++++++++++++
 tb/tb_doc_fetch_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aug_pkg.sv
// -----------------------------------------------------------------------------
// aug_pkg
// Shared definitions for the document fetch scheduler.
//   state_t    : FSM state encoding with legacy-compatible localparam states
//   calc_bpw() : bytes carried by one memory bus word
//   calc_wpd() : bus words needed to cover one document (rounded up)
// -----------------------------------------------------------------------------
package aug_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_SELECT = 2'd1;
  localparam state_t S_FETCH  = 2'd2;
  localparam state_t S_DONE   = 2'd3;

  function automatic int calc_bpw(input int bus_width);
    return bus_width / 8;
  endfunction

  function automatic int calc_wpd(input int max_seq_len, input int bus_width);
    int bpw;
    bpw = bus_width / 8;
    return (max_seq_len + bpw - 1) / bpw;
  endfunction

endpackage

// File: rtl/doc_len_scan.sv
// -----------------------------------------------------------------------------
// doc_len_scan
// Purely combinational scan of one bus word for its highest non-zero byte.
// Ports:
//   word        in  BUS_WIDTH  word to scan (byte 0 = bits [7:0])
//   has_nonzero out 1          at least one byte of the word is non-zero
//   top_byte    out IW         index of the highest non-zero byte (0 if none)
// -----------------------------------------------------------------------------
module doc_len_scan
  import aug_pkg::*;
#(
  parameter int BUS_WIDTH = 512,
  localparam int BPW = calc_bpw(BUS_WIDTH),
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic [BUS_WIDTH-1:0] word,
  output logic                 has_nonzero,
  output logic [IW-1:0]        top_byte
);

  // Later (higher) bytes overwrite earlier hits, so the last match wins.
  always_comb begin
    has_nonzero = 1'b0;
    top_byte    = '0;
    for (int i = 0; i < BPW; i++) begin
      if (word[i*8 +: 8] != 8'h00) begin
        has_nonzero = 1'b1;
        top_byte    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/doc_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// doc_fetch_scheduler
// Fetches up to TOP_K documents from a flat document store into slot buffers,
// skipping ids already fetched earlier in the same job and tracking the length
// (last non-zero byte + 1) of each fetched document.
// Optional feature: define DOC_FETCH_TIMEOUT_EN to abort a job with error=1
// when a read stalls for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a job (only honoured while idle)
//   num_docs               documents to fetch, clamped to TOP_K
//   base_addr              document store base byte address
//   doc_indices            TOP_K document ids
//   busy, done, error      job status (done is a one-cycle pulse)
//   mem_rd_en/addr         read request; mem_rd_data/valid return path
//   buf_wr_en/doc/word/data slot buffer write port
//   doc_fetched, doc_dup   per-slot completion / duplicate-skip masks
//   doc_lengths            per-slot document length in bytes
// -----------------------------------------------------------------------------
module doc_fetch_scheduler
  import aug_pkg::*;
#(
  parameter int TOP_K            = 5,
  parameter int MAX_SEQUENCE_LEN = 512,
  parameter int BUS_WIDTH        = 512,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int BPW = calc_bpw(BUS_WIDTH),
  localparam int WPD = calc_wpd(MAX_SEQUENCE_LEN, BUS_WIDTH),
  localparam int DW  = (TOP_K > 1) ? $clog2(TOP_K) : 1,
  localparam int WW  = (WPD > 1) ? $clog2(WPD) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                num_docs,
  input  logic [31:0]                base_addr,
  input  logic [TOP_K-1:0][31:0]     doc_indices,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       mem_rd_en,
  output logic [31:0]                mem_rd_addr,
  input  logic [BUS_WIDTH-1:0]       mem_rd_data,
  input  logic                       mem_rd_valid,
  output logic                       buf_wr_en,
  output logic [DW-1:0]              buf_wr_doc,
  output logic [WW-1:0]              buf_wr_word,
  output logic [BUS_WIDTH-1:0]       buf_wr_data,
  output logic [TOP_K-1:0]           doc_fetched,
  output logic [TOP_K-1:0]           doc_dup,
  output logic [TOP_K-1:0][31:0]     doc_lengths
);

  localparam int KW = $clog2(TOP_K + 1);
  localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            count_q, count_d;
  logic [WW-1:0]            w_q, w_d;
  logic [31:0]              base_q, base_d;
  logic [TOP_K-1:0][31:0]   ids_q, ids_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     mem_rd_en_q, mem_rd_en_d;
  logic [31:0]              mem_rd_addr_q, mem_rd_addr_d;
  logic                     buf_wr_en_q, buf_wr_en_d;
  logic [DW-1:0]            buf_wr_doc_q, buf_wr_doc_d;
  logic [WW-1:0]            buf_wr_word_q, buf_wr_word_d;
  logic [BUS_WIDTH-1:0]     buf_wr_data_q, buf_wr_data_d;
  logic [TOP_K-1:0]         doc_fetched_q, doc_fetched_d;
  logic [TOP_K-1:0]         doc_dup_q, doc_dup_d;
  logic [TOP_K-1:0][31:0]   doc_lengths_q, doc_lengths_d;
`ifdef DOC_FETCH_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic                     error_q, error_d;
  logic [SW-1:0]            stall_q, stall_d;
`endif

  logic                     has_nonzero;
  logic [IW-1:0]            top_byte;
  logic [TOP_K-1:0]         slot_sel;
  logic [31:0]              cur_id;
  logic                     is_dup;
  logic [31:0]              new_len;

  doc_len_scan #(.BUS_WIDTH(BUS_WIDTH)) u_scan (
    .word        (mem_rd_data),
    .has_nonzero (has_nonzero),
    .top_byte    (top_byte)
  );

  // One-hot view of the current slot k; k may equal TOP_K at the end of a
  // job, in which case no slot is selected.
  always_comb begin
    slot_sel = '0;
    cur_id   = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (k_q == KW'(i)) begin
        slot_sel[i] = 1'b1;
        cur_id      = ids_q[i];
      end
    end
    is_dup = 1'b0;
    for (int j = 0; j < TOP_K; j++) begin
      if ((KW'(j) < k_q) && (ids_q[j] == cur_id)) is_dup = 1'b1;
    end
    new_len = 32'(w_q) * 32'(BPW) + 32'(top_byte) + 32'd1;
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    count_d       = count_q;
    w_d           = w_q;
    base_d        = base_q;
    ids_d         = ids_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_rd_addr_d = mem_rd_addr_q;
    buf_wr_en_d   = 1'b0;
    buf_wr_doc_d  = buf_wr_doc_q;
    buf_wr_word_d = buf_wr_word_q;
    buf_wr_data_d = buf_wr_data_q;
    doc_fetched_d = doc_fetched_q;
    doc_dup_d     = doc_dup_q;
    doc_lengths_d = doc_lengths_q;
`ifdef DOC_FETCH_TIMEOUT_EN
    error_d       = error_q;
    stall_d       = stall_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d        = base_addr;
          ids_d         = doc_indices;
          count_d       = (num_docs > 32'(TOP_K)) ? KW'(TOP_K) : KW'(num_docs);
          k_d           = '0;
          doc_fetched_d = '0;
          doc_dup_d     = '0;
          doc_lengths_d = '0;
`ifdef DOC_FETCH_TIMEOUT_EN
          error_d       = 1'b0;
`endif
          state_d       = S_SELECT;
        end
      end

      S_SELECT: begin
        if (k_q == count_q) begin
          state_d = S_DONE;
        end else if (is_dup) begin
          doc_dup_d = doc_dup_q | slot_sel;
          k_d       = k_q + KW'(1);
        end else begin
          w_d           = '0;
          mem_rd_addr_d = base_q + cur_id * 32'(MAX_SEQUENCE_LEN);
          mem_rd_en_d   = 1'b1;
`ifdef DOC_FETCH_TIMEOUT_EN
          stall_d       = '0;
`endif
          state_d       = S_FETCH;
        end
      end

      S_FETCH: begin
        if (mem_rd_valid) begin
          buf_wr_en_d   = 1'b1;
          buf_wr_doc_d  = k_q[DW-1:0];
          buf_wr_word_d = w_q;
          buf_wr_data_d = mem_rd_data;
          if (has_nonzero) begin
            for (int i = 0; i < TOP_K; i++) begin
              if (slot_sel[i]) doc_lengths_d[i] = new_len;
            end
          end
`ifdef DOC_FETCH_TIMEOUT_EN
          stall_d = '0;
`endif
          if (w_q == WW'(WPD - 1)) begin
            doc_fetched_d = doc_fetched_q | slot_sel;
            k_d           = k_q + KW'(1);
            mem_rd_en_d   = 1'b0;
            state_d       = S_SELECT;
          end else begin
            w_d           = w_q + WW'(1);
            mem_rd_addr_d = mem_rd_addr_q + 32'(BPW);
          end
        end
`ifdef DOC_FETCH_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT_CYCLES)) begin
          error_d     = 1'b1;
          mem_rd_en_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flags are derived from the next state so they stay registered
    // yet line up with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      count_q       <= '0;
      w_q           <= '0;
      base_q        <= '0;
      ids_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_doc_q  <= '0;
      buf_wr_word_q <= '0;
      buf_wr_data_q <= '0;
      doc_fetched_q <= '0;
      doc_dup_q     <= '0;
      doc_lengths_q <= '0;
`ifdef DOC_FETCH_TIMEOUT_EN
      error_q       <= 1'b0;
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      count_q       <= count_d;
      w_q           <= w_d;
      base_q        <= base_d;
      ids_q         <= ids_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_doc_q  <= buf_wr_doc_d;
      buf_wr_word_q <= buf_wr_word_d;
      buf_wr_data_q <= buf_wr_data_d;
      doc_fetched_q <= doc_fetched_d;
      doc_dup_q     <= doc_dup_d;
      doc_lengths_q <= doc_lengths_d;
`ifdef DOC_FETCH_TIMEOUT_EN
      error_q       <= error_d;
      stall_q       <= stall_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign buf_wr_en   = buf_wr_en_q;
  assign buf_wr_doc  = buf_wr_doc_q;
  assign buf_wr_word = buf_wr_word_q;
  assign buf_wr_data = buf_wr_data_q;
  assign doc_fetched = doc_fetched_q;
  assign doc_dup     = doc_dup_q;
  assign doc_lengths = doc_lengths_q;
`ifdef DOC_FETCH_TIMEOUT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_doc_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_doc_fetch_scheduler
// Directed bench for doc_fetch_scheduler. Expected reads and buffer writes are
// queued when a job is issued; a negedge monitor pops and compares them as the
// DUT produces them. Job-level results are compared after each job.
// -----------------------------------------------------------------------------
module tb_doc_fetch_scheduler;

  localparam int TOP_K = 5;
  localparam int MSL   = 512;
  localparam int BW    = 512;
  localparam int TMO   = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [31:0]            num_docs = '0;
  logic [31:0]            base_addr = '0;
  logic [TOP_K-1:0][31:0] doc_indices = '0;
  logic                   busy, done, error;
  logic                   mem_rd_en;
  logic [31:0]            mem_rd_addr;
  logic [BW-1:0]          mem_rd_data;
  logic                   mem_rd_valid = 1'b0;
  logic                   buf_wr_en;
  logic [2:0]             buf_wr_doc;
  logic [2:0]             buf_wr_word;
  logic [BW-1:0]          buf_wr_data;
  logic [TOP_K-1:0]       doc_fetched, doc_dup;
  logic [TOP_K-1:0][31:0] doc_lengths;

  typedef struct {
    int            doc;
    int            word;
    logic [BW-1:0] data;
  } wrExp_t;

  wrExp_t      expWr[$];
  logic [31:0] expAddr[$];
  int          total = 0;
  int          bad = 0;
  int          rdCount = 0;
  int          doneCount = 0;
  int          memMode = 0;

  always #5 clk = ~clk;

  // Memory model: mode 0 puts the address in the low bytes and 0xA5 in the
  // top byte; mode 1 builds a document whose last non-zero byte is word 2,
  // byte 9 (word index taken from address bits [8:6]).
  function automatic logic [BW-1:0] memWord(input logic [31:0] addr, input int mode);
    logic [BW-1:0] w;
    w = '0;
    if (mode == 0) begin
      w = {8'hA5, 472'd0, addr};
    end else begin
      if (addr[8:6] < 3'd2) w[7:0] = 8'h11;
      else if (addr[8:6] == 3'd2) begin
        w[7:0]   = 8'h01;
        w[79:72] = 8'h3C;
      end
    end
    return w;
  endfunction

  assign mem_rd_data = memWord(mem_rd_addr, memMode);

  doc_fetch_scheduler #(
    .TOP_K(TOP_K), .MAX_SEQUENCE_LEN(MSL), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_docs(num_docs),
    .base_addr(base_addr), .doc_indices(doc_indices), .busy(busy),
    .done(done), .error(error), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .buf_wr_en(buf_wr_en),
    .buf_wr_doc(buf_wr_doc), .buf_wr_word(buf_wr_word),
    .buf_wr_data(buf_wr_data), .doc_fetched(doc_fetched),
    .doc_dup(doc_dup), .doc_lengths(doc_lengths)
  );

  task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                             input logic [BW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Queue the reads and writes one slot should produce.
  task automatic expectDoc(input int slot, input logic [31:0] id, input logic [31:0] base,
                           input int nRd, input int nWr);
    logic [31:0] a;
    for (int w = 0; w < nRd; w++) begin
      a = base + id * MSL + w * 64;
      expAddr.push_back(a);
      if (w < nWr) expWr.push_back('{slot, w, memWord(a, memMode)});
    end
  endtask

  function automatic logic validFor(input int c, input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2 == 0);
    return 1'b0;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en && mem_rd_valid) begin
        rdCount++;
        if (expAddr.size() == 0) checkOutput("rd_unexpected", mem_rd_addr, '0);
        else checkOutput("rd_addr", mem_rd_addr, expAddr.pop_front());
      end
      if (buf_wr_en) begin
        if (expWr.size() == 0) checkOutput("wr_unexpected", 1, 0);
        else begin
          wrExp_t e;
          e = expWr.pop_front();
          checkOutput("wr_doc", buf_wr_doc, e.doc);
          checkOutput("wr_word", buf_wr_word, e.word);
          checkOutput("wr_data", buf_wr_data, e.data);
        end
      end
      if (done) doneCount++;
    end
  end

  // Issue a job at the current cycle (caller is #1 past a rising edge) and
  // count cycles until done; returns aligned #1 past the next rising edge.
  task automatic applyStimulus(input int num, input logic [31:0] base,
                               input logic [TOP_K-1:0][31:0] ids, input int vMode,
                               input int bound, input bit toggleChk, output int doneCyc);
    doneCyc      = -1;
    num_docs     = num;
    base_addr    = base;
    doc_indices  = ids;
    start        = 1'b1;
    mem_rd_valid = validFor(0, vMode);
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk);
      #1;
      start        = 1'b0;
      mem_rd_valid = validFor(c, vMode);
      @(negedge clk);
      if (c == 1) checkOutput("busy_select", busy, 1);
      if (toggleChk) checkOutput("wr_en_toggle", buf_wr_en, (c % 2 == 1) && (c >= 3) && (c <= 17));
      if (done) begin
        doneCyc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_rd_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
    checkOutput({tag, "_rd_addr"}, mem_rd_addr, 0);
    checkOutput({tag, "_wr_en"}, buf_wr_en, 0);
    checkOutput({tag, "_wr_doc"}, buf_wr_doc, 0);
    checkOutput({tag, "_wr_word"}, buf_wr_word, 0);
    checkOutput({tag, "_wr_data"}, buf_wr_data, 0);
    checkOutput({tag, "_fetched"}, doc_fetched, 0);
    checkOutput({tag, "_dup"}, doc_dup, 0);
    checkOutput({tag, "_lengths"}, doc_lengths, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [TOP_K-1:0][31:0] ids;
    int dc;
    int doneBefore;

    // Reset state.
    #3;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single document, reference latency.
    memMode = 0;
    ids = '0;
    ids[0] = 32'd3;
    expectDoc(0, 3, 32'h1000, 8, 8);
    rdCount = 0;
    applyStimulus(1, 32'h1000, ids, 0, 200, 1'b0, dc);
    checkOutput("a_done_cycle", dc, 11);
    checkOutput("a_done_pulse", done, 0);
    checkOutput("a_busy_idle", busy, 0);
    checkOutput("a_fetched", doc_fetched, 5'b00001);
    checkOutput("a_dup", doc_dup, 5'b00000);
    checkOutput("a_len0", doc_lengths[0], 512);
    checkOutput("a_reads", rdCount, 8);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_hold_fetched", doc_fetched, 5'b00001);
    checkOutput("a_hold_len0", doc_lengths[0], 512);

    // Duplicate skipping.
    ids[0] = 32'd7; ids[1] = 32'd2; ids[2] = 32'd7; ids[3] = 32'd2; ids[4] = 32'd9;
    expectDoc(0, 7, 0, 8, 8);
    expectDoc(1, 2, 0, 8, 8);
    expectDoc(4, 9, 0, 8, 8);
    rdCount = 0;
    applyStimulus(5, 32'h0, ids, 0, 200, 1'b0, dc);
    checkOutput("b_done_cycle", dc, 31);
    checkOutput("b_dup", doc_dup, 5'b01100);
    checkOutput("b_fetched", doc_fetched, 5'b10011);
    checkOutput("b_reads", rdCount, 24);
    checkOutput("b_len2", doc_lengths[2], 0);
    checkOutput("b_len4", doc_lengths[4], 512);

    // Empty job clears the previous job's results.
    rdCount = 0;
    applyStimulus(0, 32'h0, ids, 0, 50, 1'b0, dc);
    checkOutput("z_done_cycle", dc, 2);
    checkOutput("z_reads", rdCount, 0);
    checkOutput("z_fetched", doc_fetched, 0);
    checkOutput("z_dup", doc_dup, 0);
    checkOutput("z_len0", doc_lengths[0], 0);

    // num_docs above TOP_K is clamped.
    ids = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    expectDoc(0, 1, 0, 8, 8);
    rdCount = 0;
    applyStimulus(9, 32'h0, ids, 0, 200, 1'b0, dc);
    checkOutput("c_done_cycle", dc, 15);
    checkOutput("c_dup", doc_dup, 5'b11110);
    checkOutput("c_fetched", doc_fetched, 5'b00001);
    checkOutput("c_reads", rdCount, 8);

    // Length from the last non-zero byte.
    memMode = 1;
    ids = '0;
    expectDoc(0, 0, 32'h1000, 8, 8);
    applyStimulus(1, 32'h1000, ids, 0, 200, 1'b0, dc);
    checkOutput("l_done_cycle", dc, 11);
    checkOutput("l_len0", doc_lengths[0], 138);
    checkOutput("l_fetched", doc_fetched, 5'b00001);

    // Toggling read valid.
    memMode = 0;
    ids[0] = 32'd5;
    expectDoc(0, 5, 0, 8, 8);
    rdCount = 0;
    applyStimulus(1, 32'h0, ids, 1, 200, 1'b1, dc);
    checkOutput("t_done_cycle", dc, 18);
    checkOutput("t_reads", rdCount, 8);

    // Reset in the middle of word 4.
    ids[0] = 32'd4;
    expectDoc(0, 4, 32'h2000, 5, 4);
    doneBefore   = doneCount;
    num_docs     = 1;
    base_addr    = 32'h2000;
    doc_indices  = ids;
    start        = 1'b1;
    mem_rd_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mem_rd_valid = 1'b0;
    checkAllZero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid_reset_no_done", doneCount, doneBefore);
    checkOutput("mid_reset_addr_left", expAddr.size(), 0);
    checkOutput("mid_reset_wr_left", expWr.size(), 0);
    rst_n = 1'b1;
    ids[0] = 32'd3;
    expectDoc(0, 3, 32'h1000, 8, 8);
    applyStimulus(1, 32'h1000, ids, 0, 200, 1'b0, dc);
    checkOutput("r_done_cycle", dc, 11);
    checkOutput("r_fetched", doc_fetched, 5'b00001);
    checkOutput("r_done_count", doneCount, doneBefore + 1);

    // Read stall.
    ids[0] = 32'd6;
`ifdef DOC_FETCH_TIMEOUT_EN
    applyStimulus(1, 32'h0, ids, 2, 100, 1'b0, dc);
    checkOutput("to_done_cycle", dc, 19);
    checkOutput("to_error", error, 1);
    checkOutput("to_fetched", doc_fetched, 0);
    checkOutput("to_rd_en", mem_rd_en, 0);
`else
    applyStimulus(1, 32'h0, ids, 2, 40, 1'b0, dc);
    checkOutput("stall_no_done", dc, -1);
    checkOutput("stall_busy", busy, 1);
    checkOutput("stall_rd_en", mem_rd_en, 1);
    checkOutput("stall_error", error, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("stall_recover_busy", busy, 0);
`endif

    checkOutput("addr_left", expAddr.size(), 0);
    checkOutput("wr_left", expWr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
